// File: rtl/ieee_rom_tdm_if.sv
// ieee_rom_tdm_if: shared ROM bus between the TDM arbiter and the ROM set.
//   master (arbiter): drives rom_addr, rom_sel, rom_type, rom_type_d; receives rom_q
//   slave  (ROM)    : receives address/select/type, drives rom_q
//   rom_addr   AW  shared ROM address
//   rom_sel    CW  channel index currently on rom_addr
//   rom_type   TW  ROM type of the channel on rom_addr
//   rom_type_d TW  rom_type delayed by the ROM read latency (aligned with rom_q)
//   rom_q      DW  ROM read data
interface ieee_rom_tdm_if #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int TW = 1,
    parameter int CW = 2
);
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_sel;
    logic [TW-1:0] rom_type;
    logic [TW-1:0] rom_type_d;
    logic [DW-1:0] rom_q;

    modport master (
        output rom_addr,
        output rom_sel,
        output rom_type,
        output rom_type_d,
        input  rom_q
    );

    modport slave (
        input  rom_addr,
        input  rom_sel,
        input  rom_type,
        input  rom_type_d,
        output rom_q
    );
endinterface

// File: rtl/ieee_rom_tdm.sv
// ieee_rom_tdm: time-division ROM arbiter. One shared ROM set serves NCH drive CPUs.
// On each ph2 strobe the enabled channels' addresses/types are snapshotted and issued
// one per clk_sys cycle in ascending index order; returning ROM data updates the
// matching per-channel data register with a one-cycle drv_valid pulse.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ph2        in   one-cycle sweep start strobe
//   ch_en      in   NCH     per-channel enable (sampled at ph2)
//   drv_addr   in   NCH*AW  channel addresses, channel i at [i*AW +: AW] (sampled at ph2)
//   drv_type   in   NCH*TW  channel ROM type (sampled at ph2)
//   rom        ieee_rom_tdm_if.master  shared ROM bus (addr/sel/type/type_d out, q in)
//   drv_data   out  NCH*DW  per-channel data registers
//   drv_valid  out  NCH     one-cycle update pulse per channel
//   busy       out  sweep or pipeline drain in progress
//   ovr        out  sticky overrun flag (ph2 seen while busy)
//   ovr_clr    in   clears ovr
//
// Build option: define ROMTDM_OVR_EN to enable the overrun flag; otherwise ovr is 0
// and ovr_clr is ignored.
module ieee_rom_tdm #(
    parameter int NCH  = 4,
    parameter int AW   = 14,
    parameter int DW   = 8,
    parameter int TW   = 1,
    parameter int RLAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ph2,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*AW-1:0] drv_addr,
    input  logic [NCH*TW-1:0] drv_type,
    ieee_rom_tdm_if.master    rom,
    output logic [NCH*DW-1:0] drv_data,
    output logic [NCH-1:0]    drv_valid,
    output logic              busy,
    output logic              ovr,
    input  logic              ovr_clr
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nx;

    // Snapshot of the sweep: channels still to issue, plus their addresses/types.
    logic [NCH-1:0]    rem_q;
    logic [NCH*AW-1:0] addr_q;
    logic [NCH*TW-1:0] type_q;

    // Read pipeline aligned with the ROM latency.
    logic [RLAT-1:0] pv;
    logic [CW-1:0]   ps [RLAT];
    logic [TW-1:0]   pt [RLAT];
    logic            iss_v;

    logic              start;
    logic              issue_go;
    logic              pipe_busy;
    logic [NCH-1:0]    src_mask;
    logic [NCH*AW-1:0] src_addr;
    logic [NCH*TW-1:0] src_type;
    logic [CW-1:0]     pick_idx;
    logic [NCH-1:0]    pick_hot;
    logic [AW-1:0]     pick_addr;
    logic [TW-1:0]     pick_type;

    assign start     = (state == IDLE) && ph2 && (|ch_en);
    assign pipe_busy = iss_v || (|pv);
    assign busy      = (state != IDLE);

    // The first channel is issued from the live inputs in the ph2 cycle so that it
    // reaches rom_addr one cycle after ph2; later channels come from the snapshot.
    always_comb begin
        src_mask  = (state == IDLE) ? ch_en    : rem_q;
        src_addr  = (state == IDLE) ? drv_addr : addr_q;
        src_type  = (state == IDLE) ? drv_type : type_q;
        pick_idx  = '0;
        pick_hot  = '0;
        pick_addr = '0;
        pick_type = '0;
        // Descending scan: the lowest set bit is the last one written.
        for (int unsigned i = NCH; i > 0; i--) begin
            if (src_mask[i-1]) begin
                pick_idx       = CW'(i-1);
                pick_hot       = '0;
                pick_hot[i-1]  = 1'b1;
                pick_addr      = src_addr[(i-1)*AW +: AW];
                pick_type      = src_type[(i-1)*TW +: TW];
            end
        end
        issue_go = start || ((state == ISSUE) && (|rem_q));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)        state_nx = ISSUE;
            ISSUE:   if (!(|rem_q))    state_nx = DRAIN;
            DRAIN:   if (!pipe_busy)   state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rem_q        <= '0;
            addr_q       <= '0;
            type_q       <= '0;
            iss_v        <= 1'b0;
            rom.rom_addr <= '0;
            rom.rom_sel  <= '0;
            rom.rom_type <= '0;
            pv           <= '0;
            for (int unsigned i = 0; i < RLAT; i++) begin
                ps[i] <= '0;
                pt[i] <= '0;
            end
            drv_data     <= '0;
            drv_valid    <= '0;
        end else begin
            if (start) begin
                addr_q <= drv_addr;
                type_q <= drv_type;
            end
            iss_v <= issue_go;
            if (issue_go) begin
                rom.rom_addr <= pick_addr;
                rom.rom_sel  <= pick_idx;
                rom.rom_type <= pick_type;
                rem_q        <= src_mask & ~pick_hot;
            end

            pv[0] <= iss_v;
            ps[0] <= rom.rom_sel;
            pt[0] <= rom.rom_type;
            for (int unsigned i = 1; i < RLAT; i++) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
                pt[i] <= pt[i-1];
            end

            drv_valid <= '0;
            if (pv[RLAT-1]) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (ps[RLAT-1] == CW'(i)) begin
                        drv_data[i*DW +: DW] <= rom.rom_q;
                        drv_valid[i]         <= 1'b1;
                    end
                end
            end
        end
    end

    assign rom.rom_type_d = pt[RLAT-1];

`ifdef ROMTDM_OVR_EN
    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ovr <= 1'b0;
        end else if (ph2 && (state != IDLE)) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign ovr            = 1'b0;
`endif

endmodule
